mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
Parametrised multicycle stage sequencer. It is the next-generation replacement for the fixed-latency control path of the multicycle RV32I core. It owns the PC register, the instruction register and the stage FSM, and it talks to memory over a req/gnt/rvalid handshake so that memory may stall for any number of cycles. It adds wait-state tolerance, a bus timeout, alignment checking and a halt/trap state, none of which the current core has.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 255, maximum cycles spent in any *_WAIT state before trap; 0 disables the timeout

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
opcode  in  7  opcode field of the current instr
next_pc  in  XLEN  next PC computed by the datapath (pc+4, branch target or jump target)
alu_result  in  XLEN  effective address for load/store
mem_gnt  in  1  memory accepted the request this cycle
mem_rvalid  in  1  read data valid, or write acknowledge
mem_rdata  in  XLEN  memory read data
mem_req  out  1  request valid
mem_we  out  1  write request
mem_addr  out  XLEN  request address
pc  out  XLEN  current PC
instr  out  32  instruction register
load_data  out  XLEN  captured load data
rf_we  out  1  register-file write enable (single-cycle pulse)
wb_sel  out  2  writeback source: 0 alu, 1 load_data, 2 pc+4
stage  out  3  current FSM state encoding
halted  out  1  high while in HALT
trap_cause  out  3  valid while halted: 0 ecall/ebreak, 1 illegal opcode, 2 bus timeout, 3 misaligned PC
retire  out  1  one-cycle pulse when an instruction completes
cycle_count  out  64  performance counter (see Optional Feature)
instret_count  out  64  performance counter (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - state=FETCH_REQ; pc=RESET_PC.
  - instr, load_data, timer, trap_cause, counters = 0.
  - All strobes (mem_req, mem_we, rf_we, retire) = 0; halted=0; wb_sel=0.
  - Reset mid-transaction abandons it. A stale mem_rvalid after reset is ignored because rvalid is only sampled in the *_WAIT states.
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT.
- FETCH_REQ:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Holds until mem_gnt=1, then goes to FETCH_WAIT. Address is stable while waiting for gnt.
  - If pc[1:0]!=0, goes to HALT with cause 3 and issues no request.
- FETCH_WAIT: on mem_rvalid, instr<=mem_rdata, then DECODE. An rvalid in the same cycle as gnt is not accepted.
- DECODE: one cycle, then EXECUTE.
  - SYSTEM (1110011) goes to HALT with cause 0.
  - Any opcode outside RV32I {LOAD, STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM} goes to HALT with cause 1.
- EXECUTE: LOAD/STORE go to MEM_REQ; all other opcodes go to WRITEBACK.
- MEM_REQ: mem_req=1, mem_addr=alu_result, mem_we=1 for STORE. Holds until mem_gnt, then MEM_WAIT.
- MEM_WAIT: on mem_rvalid, LOAD captures load_data<=mem_rdata (STORE treats rvalid as the write ack), then WRITEBACK.
- WRITEBACK:
  - rf_we=1 for LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR; 0 for STORE and BRANCH.
  - wb_sel: LOAD→1, JAL/JALR→2, otherwise 0.
  - pc<=next_pc; retire=1; next state FETCH_REQ.
  - If next_pc[1:0]!=0: HALT with cause 3, pc unchanged, rf_we=0, retire=0.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the cycle after): non-memory instruction 5 cycles; load/store 7 cycles. Each gnt or rvalid wait cycle adds one cycle.
- Timeout: the timer clears on entry to each *_REQ/*_WAIT state and increments every cycle spent there. Reaching MEM_TIMEOUT goes to HALT with cause 2. The timer saturates; it does not wrap.
- HALT: sticky until reset. halted=1, all strobes 0, pc frozen at the faulting instruction.

Optional Feature:
PERF_COUNTERS_EN:
- Defined: cycle_count increments every cycle out of reset except in HALT. instret_count increments on retire. Both are 64-bit and wrap modulo 2^64.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mc_pkg:
  - state enum;
  - RV32I opcode constants;
  - trap_cause enum;
  - wb_sel enum.
- One sub-module, mc_bus_timer: parametrised saturating wait counter with clear input and expire output, one instance shared by all wait states.

Test Plan:
- Zero-wait ADDI at RESET_PC=0 with next_pc=4: rf_we pulses in cycle 5; pc=4; retire=1; instret_count=1.
- LW with gnt delayed 3 cycles and rvalid delayed 2 cycles, mem_rdata=0xDEADBEEF: load_data=0xDEADBEEF; rf_we with wb_sel=1 at cycle 12.
- SW: mem_we=1 and mem_addr=alu_result=0x100 during MEM_REQ; rf_we stays 0; retire fires after the ack.
- Opcode 0x7F: halted=1, trap_cause=1, pc unchanged; further mem_gnt/mem_rvalid have no effect.
- MEM_TIMEOUT=8 with rvalid never asserted in FETCH_WAIT: halted=1, trap_cause=2 after exactly 8 wait cycles.
- Reset asserted in MEM_WAIT with a late rvalid 1 cycle after reset release: state=FETCH_REQ, pc=RESET_PC, late rvalid ignored; next fetch proceeds normally.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// mc_pkg: shared types and RV32I opcode constants for the multicycle
// stage sequencer (mc_sequencer) and its bus wait timer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_MEM_REQ    = 3'd4,
    ST_MEM_WAIT   = 3'd5,
    ST_WRITEBACK  = 3'd6,
    ST_HALT       = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_ECALL      = 3'd0,
    CAUSE_ILLEGAL    = 3'd1,
    CAUSE_TIMEOUT    = 3'd2,
    CAUSE_MISALIGNED = 3'd3
  } trap_cause_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // True for every opcode the sequencer knows how to step through.
  function automatic logic is_rv32i(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM: is_rv32i = 1'b1;
      default:                                   is_rv32i = 1'b0;
    endcase
  endfunction

  // Instructions that produce a register result.
  function automatic logic writes_rf(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR: writes_rf = 1'b1;
      default:           writes_rf = 1'b0;
    endcase
  endfunction

  function automatic wb_sel_t wb_source(input logic [6:0] opc);
    case (opc)
      OPC_LOAD:           wb_source = WB_LOAD;
      OPC_JAL, OPC_JALR:  wb_source = WB_PC4;
      default:            wb_source = WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: req/gnt/rvalid memory handshake between the sequencer
// (master) and the memory system (slave).
interface mc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mc_bus_timer.sv
// mc_bus_timer: saturating count of cycles spent in the current bus
// request/wait state. expire is raised during the cycle in which the count
// would reach MAX_COUNT, so the owner can leave on that same edge.
// MAX_COUNT = 0 disables expiry.
module mc_bus_timer #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT + 1) : 1;
  localparam int unsigned LIMIT = (MAX_COUNT == 0) ? 0 : MAX_COUNT - 1;
  localparam logic [W-1:0] SAT  = W'(MAX_COUNT);
  localparam logic [W-1:0] LAST = W'(LIMIT);

  logic [W-1:0] count;

  // Wait-cycle counter: cleared on state entry, held at saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (MAX_COUNT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle RV32I stage sequencer. Owns PC, instruction
// register and stage FSM; talks to memory over a req/gnt/rvalid handshake
// with a bus timeout, alignment checks and a sticky HALT/trap state.
// Optional build macro: PERF_COUNTERS_EN (cycle/instret counters).
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int unsigned      MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [XLEN-1:0]    next_pc,
  input  logic [XLEN-1:0]    alu_result,
  mc_sequencer_if.master     bus,
  output logic [XLEN-1:0]    pc,
  output logic [31:0]        instr,
  output logic [XLEN-1:0]    load_data,
  output logic               rf_we,
  output logic [1:0]         wb_sel,
  output logic [2:0]         stage,
  output logic               halted,
  output logic [2:0]         trap_cause,
  output logic               retire,
  output logic [63:0]        cycle_count,
  output logic [63:0]        instret_count
);

  state_t      state;
  state_t      state_next;
  trap_cause_t halt_cause;
  logic        timer_en;
  logic        timer_expire;
  logic        instr_cap;
  logic        load_cap;
  logic        pc_upd;

  // The timer restarts whenever the FSM changes state, which covers entry
  // into every *_REQ/*_WAIT state.
  mc_bus_timer #(
    .MAX_COUNT (MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (reset),
    .clear  (state_next != state),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // Stage state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, bus strobes and writeback controls.
  always_comb begin
    state_next   = state;
    halt_cause   = CAUSE_ECALL;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = pc;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    timer_en     = 1'b0;
    instr_cap    = 1'b0;
    load_cap     = 1'b0;
    pc_upd       = 1'b0;

    case (state)
      ST_FETCH_REQ: begin
        if (pc[1:0] != 2'b00) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_MISALIGNED;
        end else begin
          bus.mem_req = 1'b1;
          timer_en    = 1'b1;
          if (bus.mem_gnt) begin
            state_next = ST_FETCH_WAIT;
          end else if (timer_expire) begin
            state_next = ST_HALT;
            halt_cause = CAUSE_TIMEOUT;
          end
        end
      end
      ST_FETCH_WAIT: begin
        timer_en = 1'b1;
        if (bus.mem_rvalid) begin
          instr_cap  = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expire) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opcode == OPC_SYSTEM) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_ECALL;
        end else if (!is_rv32i(opcode)) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          state_next = ST_MEM_REQ;
        end else begin
          state_next = ST_WRITEBACK;
        end
      end
      ST_MEM_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = (opcode == OPC_STORE);
        bus.mem_addr = alu_result;
        timer_en     = 1'b1;
        if (bus.mem_gnt) begin
          state_next = ST_MEM_WAIT;
        end else if (timer_expire) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        timer_en = 1'b1;
        if (bus.mem_rvalid) begin
          load_cap   = (opcode == OPC_LOAD);
          state_next = ST_WRITEBACK;
        end else if (timer_expire) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        if (next_pc[1:0] != 2'b00) begin
          state_next = ST_HALT;
          halt_cause = CAUSE_MISALIGNED;
        end else begin
          rf_we      = writes_rf(opcode);
          wb_sel     = wb_source(opcode);
          retire     = 1'b1;
          pc_upd     = 1'b1;
          state_next = ST_FETCH_REQ;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH_REQ;
      end
    endcase

    // FETCH_REQ is the reset state; keep the request low while reset is held.
    if (reset) begin
      bus.mem_req = 1'b0;
    end
  end

  // PC, instruction/load capture and trap cause latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      load_data  <= '0;
      trap_cause <= '0;
    end else begin
      if (pc_upd) begin
        pc <= next_pc;
      end
      if (instr_cap) begin
        instr <= bus.mem_rdata[31:0];
      end
      if (load_cap) begin
        load_data <= bus.mem_rdata;
      end
      if ((state_next == ST_HALT) && (state != ST_HALT)) begin
        trap_cause <= halt_cause;
      end
    end
  end

  assign stage  = state;
  assign halted = (state == ST_HALT);

`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  // Performance counters: cycles outside HALT, and retired instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != ST_HALT) begin
        cycle_q <= cycle_q + 64'd1;
      end
      if (retire) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: randomized self-checking bench for mc_sequencer.
// A transaction-level model predicts, per instruction, the cycle at which it
// retires or halts from the latency/wait/timeout rules, plus PC, writeback
// controls, captured data and counters.
module tb_mc_sequencer;

  localparam int TO = 8;

  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] OPR    = 7'h33;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] SYSTEM = 7'h73;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [31:0] next_pc;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] load_data;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  stage;
  logic        halted;
  logic [2:0]  trap_cause;
  logic        retire;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  always #5 clk = ~clk;

  mc_sequencer_if #(.XLEN(32)) bus_if ();

  mc_sequencer #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .next_pc       (next_pc),
    .alu_result    (alu_result),
    .bus           (bus_if),
    .pc            (pc),
    .instr         (instr),
    .load_data     (load_data),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .stage         (stage),
    .halted        (halted),
    .trap_cause    (trap_cause),
    .retire        (retire),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0]     m_pc;
  longint unsigned m_cycles;
  longint unsigned m_ret;
  int              m_cause;

  logic [6:0] legal_ops [9] = '{LOAD, STORE, OPR, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_cnt(input longint unsigned v);
`ifdef PERF_COUNTERS_EN
    return v;
`else
    return (v == 0) ? 64'd0 : 64'd0;
`endif
  endfunction

  function automatic bit known_op(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return op == SYSTEM;
  endfunction

  function automatic bit exp_rf(input logic [6:0] op);
    return !(op == STORE || op == BRANCH);
  endfunction

  function automatic int exp_wb(input logic [6:0] op);
    if (op == LOAD) return 1;
    if (op == JAL || op == JALR) return 2;
    return 0;
  endfunction

  task automatic do_reset(input bit check_vals);
    reset = 1'b1;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = 32'h0;
    @(negedge clk);
    #1;
    if (check_vals) begin
      check_eq("rst_stage", stage, 0);
      check_eq("rst_pc", pc, 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_load_data", load_data, 0);
      check_eq("rst_strobes", {bus_if.mem_req, bus_if.mem_we, rf_we, retire, halted}, 0);
      check_eq("rst_wb_sel", wb_sel, 0);
      check_eq("rst_trap_cause", trap_cause, 0);
      check_eq("rst_counters", cycle_count | instret_count, 0);
    end
    @(negedge clk);
    reset    = 1'b0;
    m_pc     = 32'h0;
    m_cycles = 0;
    m_ret    = 0;
  endtask

  // Runs one instruction from its first FETCH_REQ cycle. gf/rf/gm/rm are the
  // extra gnt and rvalid wait cycles for the fetch and the data access.
  task automatic run_instr(input logic [6:0] op, input logic [31:0] npc, input logic [31:0] alu,
                           input logic [31:0] ld, input int gf, input int rf, input int gm,
                           input int rm);
    logic [31:0] fword;
    logic [31:0] aexp;
    int exp_end;
    int exp_cause = 0;
    bit exp_halt  = 1'b1;
    bit is_mem;
    int txn = 0, age = 0, pend = -1, rc = 0, hc = 0, n_rf = 0, n_ret = 0;
    int gw, rw;
    fword      = $urandom();
    fword[6:0] = op;
    is_mem     = (op == LOAD) || (op == STORE);

    if (gf >= TO) begin
      exp_end = TO + 1; exp_cause = 2;
    end else if (rf >= TO) begin
      exp_end = gf + 2 + TO; exp_cause = 2;
    end else if (op == SYSTEM) begin
      exp_end = gf + rf + 4; exp_cause = 0;
    end else if (!known_op(op)) begin
      exp_end = gf + rf + 4; exp_cause = 1;
    end else if (is_mem && gm >= TO) begin
      exp_end = gf + rf + 5 + TO; exp_cause = 2;
    end else if (is_mem && rm >= TO) begin
      exp_end = gf + rf + gm + 6 + TO; exp_cause = 2;
    end else begin
      exp_end = is_mem ? 7 + gf + rf + gm + rm : 5 + gf + rf;
      if (npc[1:0] != 2'b00) begin
        exp_end++; exp_cause = 3;
      end else begin
        exp_halt = 1'b0;
      end
    end

    opcode = op; next_pc = npc; alu_result = alu;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      #1;
      if (cyc == 1) begin
        check_eq("pc_at_fetch", pc, m_pc);
        check_eq("instret_at_fetch", instret_count, exp_cnt(m_ret));
      end
      if (halted) begin
        hc = cyc;
        bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
        break;
      end
      n_rf  += rf_we;
      n_ret += retire;
      if (retire) begin
        rc = cyc;
        check_eq("wb_rf_we", rf_we, exp_rf(op));
        check_eq("wb_sel", wb_sel, exp_wb(op));
        check_eq("wb_instr", instr, fword);
        check_eq("wb_cycle_count", cycle_count, exp_cnt(m_cycles + cyc - 1));
        if (op == LOAD) check_eq("load_data", load_data, ld);
      end
      gw   = (txn == 0) ? gf : gm;
      rw   = (txn == 0) ? rf : rm;
      aexp = (txn == 0) ? m_pc : alu;
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = $urandom();
      if (pend >= 0) begin
        if (pend == rw) begin
          bus_if.mem_rvalid = 1'b1;
          bus_if.mem_rdata  = (txn == 0) ? fword : ld;
          pend = -1;
          txn  = 1;
        end else begin
          pend++;
        end
      end else if (bus_if.mem_req) begin
        check_eq(txn == 0 ? "fetch_addr" : "mem_addr", bus_if.mem_addr, aexp);
        check_eq(txn == 0 ? "fetch_we" : "mem_we", bus_if.mem_we, (txn == 1) && (op == STORE));
        if (age == gw) begin
          bus_if.mem_gnt    = 1'b1;
          bus_if.mem_rvalid = 1'($urandom_range(0, 1));
          pend = 0;
          age  = 0;
        end else begin
          age++;
        end
      end else begin
        bus_if.mem_rvalid = 1'($urandom_range(0, 1));
      end
      if (rc != 0) begin
        bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end

    if (exp_halt) begin
      check_eq("halt_cycle", hc, exp_end);
      check_eq("halt_cause", trap_cause, exp_cause);
      check_eq("halt_pc", pc, m_pc);
      check_eq("halt_no_retire", n_ret + n_rf, 0);
      check_eq("halt_cycle_count", cycle_count, exp_cnt(m_cycles + hc - 1));
      if (exp_cause < 2) check_eq("halt_instr", instr, fword);
      m_cause  = exp_cause;
      m_cycles = m_cycles + hc - 1;
    end else begin
      check_eq("retire_cycle", rc, exp_end);
      check_eq("rf_we_pulses", n_rf, exp_rf(op));
      m_pc     = npc;
      m_ret    = m_ret + 1;
      m_cycles = m_cycles + exp_end;
    end
  endtask

  // Bus activity in HALT must have no effect.
  task automatic poke_halted(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.mem_gnt    = 1'($urandom_range(0, 1));
      bus_if.mem_rvalid = 1'($urandom_range(0, 1));
      bus_if.mem_rdata  = $urandom();
      @(negedge clk);
      #1;
      check_eq("halt_sticky", {halted, stage}, {1'b1, 3'd7});
      check_eq("halt_strobes", {bus_if.mem_req, rf_we, retire}, 0);
      check_eq("halt_pc_frozen", pc, m_pc);
      check_eq("halt_cause_held", trap_cause, m_cause);
      check_eq("halt_count_frozen", cycle_count, exp_cnt(m_cycles));
    end
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 2));
  endfunction

  task automatic random_run(input int n);
    logic [6:0]  op;
    logic [31:0] npc;
    for (int i = 0; i < n; i++) begin
      op  = legal_ops[$urandom_range(0, 8)];
      npc = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
      run_instr(op, npc, $urandom(), $urandom(),
                rand_wait(), rand_wait(), rand_wait(), rand_wait());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    opcode = OPIMM; next_pc = 32'h0; alu_result = 32'h0;
    do_reset(1'b1);

    run_instr(OPIMM, 32'h4, 32'h1234, 32'h0, 0, 0, 0, 0);
    run_instr(LOAD, 32'h8, 32'h200, 32'hDEADBEEF, 0, 0, 3, 2);
    run_instr(STORE, 32'hC, 32'h100, 32'h0, 1, 1, 2, 1);
    random_run(24);

    run_instr(7'h7F, m_pc + 32'd4, 32'h0, 32'h0, 0, 0, 0, 0);
    poke_halted(6);

    do_reset(1'b0);
    run_instr(SYSTEM, 32'h4, 32'h0, 32'h0, 1, 0, 0, 0);
    poke_halted(3);

    do_reset(1'b0);
    run_instr(OPR, 32'h6, 32'h0, 32'h0, 0, 0, 0, 0);
    poke_halted(3);

    do_reset(1'b0);
    run_instr(OPR, 32'h4, 32'h0, 32'h0, 0, 1000, 0, 0);
    poke_halted(3);

    do_reset(1'b0);
    run_instr(LOAD, 32'h4, 32'h40, 32'h0, 1, 1, 1000, 0);
    poke_halted(3);

    // Reset abandoned in MEM_WAIT, then a stale rvalid after release.
    do_reset(1'b0);
    opcode = LOAD; next_pc = 32'h4; alu_result = 32'h40;
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = {25'h0, LOAD};
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0;
    #1;
    check_eq("mid_stage_mem_wait", stage, 5);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_stage", stage, 0);
    check_eq("mid_rst_pc", pc, 0);
    check_eq("mid_rst_req", bus_if.mem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'hBAD0_BAD3;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    #1;
    check_eq("stale_rvalid_stage", stage, 0);
    check_eq("stale_rvalid_data", {instr, load_data}, 64'h0);
    check_eq("stale_rvalid_req", bus_if.mem_req, 1);
    m_pc = 32'h0; m_ret = 0; m_cycles = 2;
    run_instr(OPIMM, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0);
    random_run(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
